// File: rtl/pixel_column_readout_ctrl.sv
// pixel_column_readout_ctrl
//
// Column-end readout controller for one column of pixel-region latency
// memories. L1 trigger IDs are queued in a small FIFO. Each queued ID is
// presented on l1_req_o, and the controller then walks the region token chain.
// For every region that holds the token, it emits one hit word and strobes
// read_data_o to retire that region's entry. Every event is closed with an
// end-of-event (EOE) word on the valid/ready output stream.
//
// Optional feature macro: RD53_READOUT_HITCAP_EN. When it is defined, an event
// is closed with ovf=1 as soon as its MAX_HITS-th hit word is accepted.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   trig_valid_i   push trig_id_i into the trigger FIFO
//   trig_id_i      L1 trigger ID
//   trig_full_o    trigger FIFO full
//   trig_drop_o    one-cycle pulse: a push was lost because the FIFO was full
//   l1_req_o       trigger ID currently requested from the regions
//   tok_column_i   token out of the top of the column chain
//   region_addr_i  address of the enabled region
//   region_data_i  4x4-bit ToT of the enabled region
//   read_data_o    one-cycle read strobe to the enabled region
//   out_valid_o    output word valid
//   out_ready_i    output word accepted by the sink
//   out_data_o     hit word {0, l1, addr, tot} or EOE word {1, l1, ovf, 0.., hitcount}
//   busy_o         FSM not idle, or trigger FIFO non-empty

module pixel_column_readout_ctrl #(
  parameter int unsigned TRIG_DEPTH    = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned MAX_HITS      = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trig_valid_i,
  input  logic [4:0]          trig_id_i,
  output logic                trig_full_o,
  output logic                trig_drop_o,
  output logic [4:0]          l1_req_o,
  input  logic                tok_column_i,
  input  logic [ADDR_W-1:0]   region_addr_i,
  input  logic [15:0]         region_data_i,
  output logic                read_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [21+ADDR_W:0]  out_data_o,
  output logic                busy_o
);

  localparam int unsigned PtrW = (TRIG_DEPTH > 1) ? $clog2(TRIG_DEPTH) : 1;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned OutW = 22 + ADDR_W;

  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [PtrW:0]   PtrOne     = (PtrW + 1)'(1);

`ifdef RD53_READOUT_HITCAP_EN
  localparam bit HitCapEn = 1'b1;
`else
  localparam bit HitCapEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StSettle, StCheck, StRead, StEoe} state_e;

  state_e state_q, state_d;

  // Trigger FIFO. The pointers carry one extra wrap bit to tell full from empty.
  logic [4:0]    fifo_q [TRIG_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full, push, pop;
  logic          drop_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  // The head entry is only retired once its EOE word is accepted.
  assign pop        = (state_q == StEoe) && out_ready_i;
  // A simultaneous pop frees the slot, so a push while full is still honoured.
  assign push       = trig_valid_i && (!fifo_full || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < TRIG_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      drop_q <= trig_valid_i && fifo_full && !pop;
      if (push) begin
        fifo_q[wr_ptr_q[PtrW-1:0]] <= trig_id_i;
        wr_ptr_q                   <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Event state
  logic [4:0]        l1_req_q, l1_req_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        hit_cnt_q, hit_cnt_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       tot_q, tot_d;
  logic              read_q, read_d;
  logic              cap_hit;

  // True when the hit being accepted is the MAX_HITS-th one of the event.
  assign cap_hit = HitCapEn && ((32'(hit_cnt_q) + 32'd1) >= MAX_HITS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      l1_req_q  <= '0;
      cnt_q     <= '0;
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
      addr_q    <= '0;
      tot_q     <= '0;
      read_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      l1_req_q  <= l1_req_d;
      cnt_q     <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
      ovf_q     <= ovf_d;
      addr_q    <= addr_d;
      tot_q     <= tot_d;
      read_q    <= read_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    l1_req_d  = l1_req_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_cnt_q;
    ovf_d     = ovf_q;
    addr_d    = addr_q;
    tot_d     = tot_q;
    read_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          l1_req_d  = fifo_q[rd_ptr_q[PtrW-1:0]];
          cnt_d     = SettleLoad;
          hit_cnt_d = '0;
          ovf_d     = 1'b0;
          state_d   = StSettle;
        end
      end
      // Let the token chain ripple after an L1Req change or a region read.
      StSettle: begin
        if (cnt_q <= CntOne) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StCheck: begin
        if (tok_column_i) begin
          addr_d  = region_addr_i;
          tot_d   = region_data_i;
          state_d = StRead;
        end else begin
          state_d = StEoe;
        end
      end
      StRead: begin
        if (out_ready_i) begin
          read_d = 1'b1;
          if (hit_cnt_q != 8'hff) begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
          if (cap_hit) begin
            // Remaining regions stay unread for this trigger.
            ovf_d   = 1'b1;
            state_d = StEoe;
          end else begin
            cnt_d   = SettleLoad;
            state_d = StSettle;
          end
        end
      end
      StEoe: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_data_o = '0;
    if (state_q == StRead) begin
      out_data_o = {1'b0, l1_req_q, addr_q, tot_q};
    end else begin
      out_data_o[OutW-1]      = 1'b1;
      out_data_o[OutW-2 -: 5] = l1_req_q;
      out_data_o[ADDR_W+15]   = ovf_q;
      out_data_o[7:0]         = hit_cnt_q;
    end
  end

  assign out_valid_o = (state_q == StRead) || (state_q == StEoe);
  assign read_data_o = read_q;
  assign l1_req_o    = l1_req_q;
  assign trig_full_o = fifo_full;
  assign trig_drop_o = drop_q;
  assign busy_o      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: doc/pixel_column_readout_ctrl.md
# pixel_column_readout_ctrl

Column-end readout controller that drives the trigger-matched readout of one column of pixel-region latency memories. It queues L1 trigger IDs, presents each on the column `L1Req` bus, and follows the region token chain. For every region holding the token it captures the region address and ToT, then strobes `ReadData` to retire that entry. Each event is closed with an end-of-event word on a valid/ready output stream toward the chip-level data merger.

## Interface
- `TRIG_DEPTH`, 8: trigger-ID FIFO depth; power of two, at least 2.
- `SETTLE_CYCLES`, 2: token-chain ripple allowance in cycles after `L1Req` changes or after a read; at least 1.
- `ADDR_W`, 6: region address width.
- `MAX_HITS`, 64: per-event hit cap; used only with `RD53_READOUT_HITCAP_EN`.
- `Clk` in 1: single clock; all logic on the rising edge.
- `Reset` in 1: asynchronous, active-high; all state cleared.
- `TrigValid` in 1: pushes `TrigId` when high.
- `TrigId` in 5: L1 trigger ID to be read out.
- `TrigFull` out 1: FIFO full.
- `TrigDrop` out 1: one-cycle pulse when a push is lost because the FIFO is full.
- `L1Req` out 5: trigger ID currently requested from the regions.
- `TokColumn` in 1: token out of the top of the column chain; high when any region has data ready.
- `RegionAddr` in `ADDR_W`: address of the region currently enabled.
- `RegionData` in 16: 4×4-bit ToT of the enabled region, pixel order 0..3 in the low-to-high nibbles.
- `ReadData` out 1: one-cycle read strobe to the enabled region.
- `OutValid` out 1, `OutReady` in 1: output handshake.
- `OutData` out 22+`ADDR_W`: output word, described under Operation.
- `Busy` out 1: high whenever the state is not IDLE or the FIFO is non-empty.

## Operation
- Hit word format: `{0, L1Req[4:0], RegionAddr, RegionData}`.
- End-of-event (EOE) word format: `{1, L1Req[4:0], ovf, 0…, hitcount[7:0]}`. `ovf` sits at bit 16+`ADDR_W`-1; `hitcount` occupies bits 7:0.
- FSM states: IDLE, SETTLE, CHECK, READ, EOE.
- IDLE, FIFO non-empty: register the FIFO head into `L1Req`, load the settle counter with `SETTLE_CYCLES`, clear `hitcount`, go to SETTLE.
- SETTLE: decrement the counter. At 1, go to CHECK.
- CHECK, `TokColumn`=1: capture `RegionAddr`/`RegionData` into the output register, go to READ.
- CHECK, `TokColumn`=0: go to EOE.
- READ: hold `OutValid`=1 with the hit word stable until `OutReady`. On accept:
  - assert `ReadData` on the next cycle for exactly one cycle;
  - increment `hitcount`, saturating at 255;
  - reload the settle counter, go to SETTLE.
- EOE: hold `OutValid`=1 with the EOE word. On accept, pop the FIFO and go to IDLE.
- FIFO push and pop in the same cycle are both honoured, including when the FIFO is full. A push while full with no pop is dropped and pulses `TrigDrop`.
- `L1Req` holds its value from IDLE exit until the next IDLE exit.
- `OutData` is don't-care while `OutValid`=0. `OutValid` never drops without an accept.

## Timing
- Reset values: `L1Req`=0, `ReadData`=0, `OutValid`=0, `TrigFull`=0, `TrigDrop`=0, `Busy`=0. FIFO empty, state IDLE.
- Reset asserted mid-event aborts it with no EOE emitted. `ReadData` deasserts immediately.
- Trigger pushed at cycle 0 into an empty FIFO while the FSM is idle:
  - `L1Req` valid from cycle 2;
  - first CHECK at cycle 2+`SETTLE_CYCLES`;
  - first `OutValid` at cycle 3+`SETTLE_CYCLES`.
- Per hit with `OutReady` held high: `SETTLE_CYCLES`+2 cycles, measured from one accept to the next.
- Empty event: EOE `OutValid` at cycle 3+`SETTLE_CYCLES`.
- `ReadData` is never asserted in the same cycle as a CHECK sample. The token is re-sampled only after a full settle.

## Configuration
- `RD53_READOUT_HITCAP_EN` defined:
  - when the `MAX_HITS`-th hit word is accepted, go directly to EOE with `ovf`=1;
  - `ReadData` is still issued for that last hit;
  - any remaining regions are left unread for this trigger.
- Undefined: no cap, `ovf` always 0, `hitcount` saturates at 255.

## Test plan
- Idle column (`TokColumn`=0), `SETTLE_CYCLES`=2, push ID 5: EOE word tag=1, trig=5, hitcount=0 with `OutValid` at cycle 5; `Busy` low the cycle after accept.
- Three regions (addr 3, 9, 40) with the token modelled as dropping one region per `ReadData`, trigger 17: hit words in order 3, 9, 40, each ToT as driven; exactly three one-cycle `ReadData` pulses; EOE hitcount=3.
- `OutReady` held low for 10 cycles during a hit: `OutData`/`OutValid` stable for all 10; no `ReadData` until the cycle after accept.
- Push 9 IDs with depth 8 and no pops: `TrigFull`=1 after the 8th push, one `TrigDrop` pulse, and the 9th ID is never requested. Push while full together with a pop: no drop.
- With `RD53_READOUT_HITCAP_EN` and `MAX_HITS`=2, token held high for 5 regions: 2 hit words, then EOE with ovf=1 and hitcount=2. Without the macro: 5 hits, ovf=0.
- `Reset` pulsed during READ: all outputs at reset values; FIFO empty. The next trigger is read out normally.
